// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word width, RAM handshake status and arbiter states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive data completions while instruction fetch waits; saturates at STARVE_MAX.
module arb_starve_cnt
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With STARVE_MAX = 0 this is permanently set, so fetch wins every tie.
    assign sat = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/memory_arbiter.sv
// Shares the unified RAM port between instruction fetch and data load/store,
// data first, with a bounded run of data grants before fetch is forced in.
//
// state  | meaning
// IDLE   | no grant; RAM enables low, arbitration decided at the next edge
// DGRANT | data requester owns the RAM port until ACCESS or abort
// IGRANT | instruction fetch owns the RAM port until ACCESS or abort
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      ramREN,
    output logic      ramWEN,
    output logic      ramerr
);

    arb_state_t state_q, state_d;
    logic       ramerr_q, ramerr_d;
    logic       cnt_inc, cnt_clr, starve_sat;
    logic       d_req, ram_done;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);

    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .CLK (CLK),
        .nRST(nRST),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .sat (starve_sat)
    );

    always_comb begin
        state_d  = state_q;
        ramerr_d = ramerr_q | ((state_q != IDLE) && (ramstate == ERROR));
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(iREN && starve_sat)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                if (ram_done) begin
                    state_d = IDLE;
                    cnt_inc = iREN;
                    cnt_clr = ~iREN;
                end else if (!d_req) begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                if (ram_done) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            ramerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ramerr_q <= ramerr_d;
        end
    end

    // Enables follow the live request so an abort drops them in the same cycle.
    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        iwait    = iREN;
        dwait    = d_req;
        case (state_q)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ram_done;
            end
            IGRANT: begin
                ramaddr  = iaddr;
                ramREN   = iREN;
                iwait    = ~ram_done;
            end
            default: ;
        endcase
    end

    assign iload  = ramload;
    assign dload  = ramload;
    assign ramerr = ramerr_q;

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sequential arbiter that shares the single unified RAM port between the instruction-fetch requester and the data (load/store) requester of the CPU datapath.
- Data accesses have priority. A starvation counter forces an instruction grant after a bounded run of data grants.
- Holds each grant until the RAM reports completion, drives per-requester wait signals, and flags RAM errors.

Parameters:
- STARVE_MAX, 4: maximum consecutive completed data accesses while iREN stays pending before instruction is forced ahead. Legal range 0..15; 0 means instruction always wins a tie.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request
- iaddr  input  32 (word_t)  instruction address
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  32 (word_t)  data address
- dstore  input  32 (word_t)  data write value
- ramload  input  32 (word_t)  RAM read data
- ramstate  input  2 (ramstate_t)  RAM status: FREE, BUSY, ACCESS, ERROR
- iwait  output  1  high while the instruction request is not yet serviced
- dwait  output  1  high while the data request is not yet serviced
- iload  output  32  instruction read data
- dload  output  32  data read data
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramerr  output  1  sticky flag: RAM reported ERROR during a grant

Behaviour:
- Reset (nRST low, asynchronous):
  - state=IDLE, starve_cnt=0, ramerr=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=iREN, dwait=dREN|dWEN.
- FSM states: IDLE, DGRANT, IGRANT. All grants are registered.
- IDLE (RAM enables 0, ramaddr=0, ramstore=0):
  - Data pending (dREN|dWEN) and not (iREN and starve_cnt>=STARVE_MAX): go to DGRANT.
  - Otherwise, iREN: go to IGRANT.
  - Otherwise stay in IDLE.
  - Minimum latency from request to first RAM enable: 1 cycle.
- DGRANT:
  - ramaddr=daddr. ramWEN=dWEN. ramREN=dREN&~dWEN (write wins if both are asserted). ramstore=dstore.
  - dwait = ~(ramstate==ACCESS). iwait=iREN.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - iwait = ~(ramstate==ACCESS). dwait=dREN|dWEN.
- iload and dload always equal ramload; they are valid only in the cycle the matching wait is low.
- Completion: in the cycle ramstate==ACCESS while granted, the next state is IDLE.
  - This gives one mandatory idle cycle between transactions, so a requester still holding its request in the completion cycle is never re-granted twice.
- Abort: if the granted requester deasserts its request before ACCESS, the RAM enables drop that same cycle and the next state is IDLE.
- BUSY / FREE while granted: hold state, outputs stable, wait stays high.
- ERROR while granted:
  - Hold state, wait stays high.
  - ramerr is set at the next edge and stays set until reset.
- Starvation counter:
  - Width 4.
  - Data completion with iREN high: increment, saturating at STARVE_MAX.
  - Data completion with iREN low: clear.
  - Instruction completion: clear.
- Reset asserted mid-grant: immediately return to IDLE. Enables deassert asynchronously; no completion is reported.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (FREE, BUSY, ACCESS, ERROR), and arb_state_t (IDLE, DGRANT, IGRANT).
- The FSM, output mux and counter stay in one module.
- The starvation counter is the single natural sub-module: arb_starve_cnt. Its ports are CLK, nRST, inc, clr and sat, with STARVE_MAX as a parameter.

Test Plan:
- Instruction-only read, iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0x8C010004 → ramREN=1, ramaddr=0x40 from cycle 1. iwait low only in the ACCESS cycle with iload=0x8C010004. IDLE next cycle.
- dREN and iREN both asserted at cycle 0 → DGRANT first (ramaddr=daddr=0x100). After that ACCESS, one IDLE cycle, then IGRANT. iwait is high throughout the data access.
- dWEN and dREN together, daddr=0x200, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF. dwait drops on ACCESS.
- STARVE_MAX=2, iREN held high and data requests back-to-back → exactly 2 data completions, then IGRANT even though data is pending. Counter clears after the instruction completion.
- ramstate=ERROR for 3 cycles during DGRANT, then ACCESS → dwait stays high through ERROR. ramerr=1 from the edge after the first ERROR cycle and remains 1 after completion.
- nRST pulsed low mid-IGRANT with BUSY → ramREN=0 immediately and the state is IDLE. On release with iREN high, IGRANT is re-entered 1 cycle later.
